// File: rtl/stream_arbiter_if.sv
// stream_arbiter_if: N requester streams plus the shared stb/ack output channel
// Signals:
//   input_in/_stb/_lock/_ack : requester i uses input_in[i*WIDTH +: WIDTH] and bit i of the strobes
//   output_out/_stb/_ack     : shared buffered output channel
//   output_source            : requester index that supplied output_out
// Modports: master = arbiter side, slave = requesters plus downstream side
interface stream_arbiter_if #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH = 32
);
  localparam int SW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  logic [N_INPUTS*WIDTH-1:0] input_in;
  logic [N_INPUTS-1:0] input_in_stb;
  logic [N_INPUTS-1:0] input_in_lock;
  logic [N_INPUTS-1:0] input_in_ack;
  logic [WIDTH-1:0] output_out;
  logic output_out_stb;
  logic output_out_ack;
  logic [SW-1:0] output_source;
  modport master (
    input input_in, input_in_stb, input_in_lock, output_out_ack,
    output input_in_ack, output_out, output_out_stb, output_source
  );
  modport slave (
    output input_in, input_in_stb, input_in_lock, output_out_ack,
    input input_in_ack, output_out, output_out_stb, output_source
  );
endinterface

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter funnelling N stb/ack streams into one buffered output
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : stream_arbiter_if.master (requester inputs, shared output channel)
//   exception : sticky flag, set when a stale lock is released by the watchdog
module stream_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH = 32,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  stream_arbiter_if.master bus,
  output logic exception
);
  localparam int SW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] LAST_RST = SW'(N_INPUTS - 1);
  localparam logic [TW-1:0] WD_MAX = TW'(LOCK_TIMEOUT - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0] src_q, src_d, last_q, last_d, win;
  logic [TW-1:0] wd_q, wd_d;
  logic locked_q, locked_d, exc_q, exc_d, found, stale;
  int idx;
  always_comb begin
    win = last_q;
    found = 1'b0;
    idx = 0;
    // scan farthest-first so the nearest requester after last_grant is written last and wins
    for (int k = N_INPUTS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N_INPUTS;
      if (bus.input_in_stb[idx]) begin
        win = SW'(idx);
        found = 1'b1;
      end
    end
    if (locked_q) begin
      win = last_q;
      found = bus.input_in_stb[last_q];
    end
    found = found && state_q == IDLE;
    stale = state_q == IDLE && locked_q && !bus.input_in_stb[last_q];
    bus.input_in_ack = found ? N_INPUTS'(1) << win : '0;
    state_d = state_q;
    out_d = out_q;
    src_d = src_q;
    last_d = last_q;
    locked_d = locked_q;
    exc_d = exc_q;
    // the timeout fires on the LOCK_TIMEOUT-th stale idle cycle, so the grant is free the cycle after
    wd_d = (stale && wd_q != WD_MAX) ? wd_q + 1'b1 : '0;
    if (stale && wd_q == WD_MAX) begin
      locked_d = 1'b0;
      exc_d = 1'b1;
    end
    if (found) begin
      state_d = SEND;
      out_d = bus.input_in[win*WIDTH +: WIDTH];
      src_d = win;
      last_d = win;
      locked_d = bus.input_in_lock[win];
    end
    if (state_q == SEND && bus.output_out_ack) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q <= '0;
      src_q <= '0;
      last_q <= LAST_RST;
      locked_q <= 1'b0;
      exc_q <= 1'b0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      src_q <= src_d;
      last_q <= last_d;
      locked_q <= locked_d;
      exc_q <= exc_d;
      wd_q <= wd_d;
    end
  end
  assign bus.output_out = out_q;
  assign bus.output_out_stb = state_q == SEND;
  assign bus.output_source = src_q;
  assign exception = exc_q;
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed scenario tests for stream_arbiter
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic exception;
  int checks = 0;
  int errors = 0;
  stream_arbiter_if #(.N_INPUTS(4), .WIDTH(32)) bus ();
  stream_arbiter #(.N_INPUTS(4), .WIDTH(32), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .exception(exception)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.input_in = '0;
    bus.input_in_stb = '0;
    bus.input_in_lock = '0;
    bus.output_out_ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus.output_out_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", bus.output_out_stb); end
    checks++;
    if (bus.output_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", bus.output_out); end
    checks++;
    if (bus.output_source !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", bus.output_source); end
    checks++;
    if (bus.input_in_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", bus.input_in_ack); end
    checks++;
    if (exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", exception); end
  endtask

  task automatic test_single;
    int xfers;
    do_reset();
    bus.input_in[2*32 +: 32] = 32'h12345678;
    bus.input_in_stb = 4'b0100;
    bus.output_out_ack = 1'b1;
    #1;
    checks++;
    if (bus.input_in_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", bus.input_in_ack); end
    tick();
    checks++;
    if (bus.output_out_stb !== 1'b1 || bus.output_out !== 32'h12345678 || bus.output_source !== 2'd2) begin
      errors++;
      $display("FAIL single_out got stb=%b out=%h src=%0d want stb=1 out=12345678 src=2", bus.output_out_stb, bus.output_out, bus.output_source);
    end
    checks++;
    if (bus.input_in_ack !== 4'b0) begin errors++; $display("FAIL single_send_ack got %b want 0000", bus.input_in_ack); end
    xfers = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.output_out_stb && bus.output_out_ack) xfers++;
    end
    bus.input_in_stb = 4'b0;
    checks++;
    if (xfers !== 4) begin errors++; $display("FAIL single_rate got %0d words want 4 in 7 cycles", xfers); end
  endtask

  task automatic test_fairness;
    int n;
    int exp_src [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 4; i++) bus.input_in[i*32 +: 32] = 32'hA0 + i;
    bus.input_in_stb = 4'b1111;
    bus.output_out_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.output_out_stb && n < 8) begin
        checks++;
        if (bus.output_source !== 2'(exp_src[n]) || bus.output_out !== 32'hA0 + exp_src[n]) begin
          errors++;
          $display("FAIL fair_word%0d got src=%0d out=%h want src=%0d out=%h", n, bus.output_source, bus.output_out, exp_src[n], 32'hA0 + exp_src[n]);
        end
        n++;
      end
    end
    bus.input_in_stb = 4'b0;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL fair_count got %0d want 8", n); end
  endtask

  task automatic test_backpressure;
    int xfers;
    int bad;
    do_reset();
    bus.input_in[1*32 +: 32] = 32'hCAFEBABE;
    bus.input_in_stb = 4'b0010;
    tick();
    bus.input_in[1*32 +: 32] = 32'h11111111;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.output_out !== 32'hCAFEBABE || bus.output_out_stb !== 1'b1 || bus.input_in_ack !== 4'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stall got %0d bad cycles want 0", bad); end
    bus.input_in_stb = 4'b0;
    bus.output_out_ack = 1'b1;
    #1;
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.output_out_stb && bus.output_out_ack) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 1) begin errors++; $display("FAIL bp_xfers got %0d want 1", xfers); end
  endtask

  task automatic test_lock;
    int w1, n;
    logic d0, d3;
    logic [3:0] a;
    logic [1:0] got_src [5];
    logic [31:0] got_out [5];
    logic [1:0] exp_src [5] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
    logic [31:0] exp_out [5] = '{32'h101, 32'h102, 32'h103, 32'hD3, 32'hD0};
    do_reset();
    bus.output_out_ack = 1'b1;
    bus.input_in[0 +: 32] = 32'hD0;
    bus.input_in[3*32 +: 32] = 32'hD3;
    w1 = 0; n = 0; d0 = 1'b0; d3 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.input_in[1*32 +: 32] = 32'h101 + w1;
      bus.input_in_lock = {2'b00, w1 < 2, 1'b0};
      bus.input_in_stb = {w1 >= 1 && !d3, 1'b0, w1 < 3, w1 >= 1 && !d0};
      #1;
      a = bus.input_in_ack;
      if (bus.output_out_stb && n < 5) begin
        got_src[n] = bus.output_source;
        got_out[n] = bus.output_out;
        n++;
      end
      tick();
      if (a[1]) w1++;
      if (a[0]) d0 = 1'b1;
      if (a[3]) d3 = 1'b1;
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lock_count got %0d want 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_src[i] !== exp_src[i] || got_out[i] !== exp_out[i]) begin
        errors++;
        $display("FAIL lock_word%0d got src=%0d out=%h want src=%0d out=%h", i, got_src[i], got_out[i], exp_src[i], exp_out[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int bad;
    do_reset();
    bus.output_out_ack = 1'b1;
    bus.input_in[1*32 +: 32] = 32'h55;
    bus.input_in[2*32 +: 32] = 32'h22;
    bus.input_in_lock = 4'b0010;
    bus.input_in_stb = 4'b0010;
    #1;
    checks++;
    if (bus.input_in_ack !== 4'b0010) begin errors++; $display("FAIL to_first_ack got %b want 0010", bus.input_in_ack); end
    tick();
    bus.input_in_stb = 4'b0100;
    bus.input_in_lock = 4'b0;
    checks++;
    if (bus.output_source !== 2'd1 || exception !== 1'b0) begin errors++; $display("FAIL to_send got src=%0d exc=%b want src=1 exc=0", bus.output_source, exception); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.input_in_ack !== 4'b0 || exception !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL to_hold got %0d bad idle cycles want 0", bad); end
    tick();
    checks++;
    if (exception !== 1'b1 || bus.input_in_ack !== 4'b0100) begin errors++; $display("FAIL to_fire got exc=%b ack=%b want exc=1 ack=0100", exception, bus.input_in_ack); end
    tick();
    checks++;
    if (bus.output_source !== 2'd2 || bus.output_out !== 32'h22) begin errors++; $display("FAIL to_grant2 got src=%0d out=%h want src=2 out=22", bus.output_source, bus.output_out); end
    bus.input_in_stb = 4'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (exception !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL to_sticky got %0d low cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_send;
    bus.output_out_ack = 1'b0;
    bus.input_in[3*32 +: 32] = 32'h33;
    bus.input_in_stb = 4'b1000;
    tick();
    checks++;
    if (bus.output_out_stb !== 1'b1 || bus.output_source !== 2'd3) begin errors++; $display("FAIL rst_pre got stb=%b src=%0d want stb=1 src=3", bus.output_out_stb, bus.output_source); end
    bus.input_in_stb = 4'b1001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.output_out_stb !== 1'b0 || exception !== 1'b0 || bus.output_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got stb=%b exc=%b out=%h want stb=0 exc=0 out=0", bus.output_out_stb, exception, bus.output_out);
    end
    #1;
    checks++;
    if (bus.input_in_ack !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", bus.input_in_ack); end
    bus.input_in_stb = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lock();
    test_timeout();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
